data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Two-port arbiter and sequencer in front of the 128 x 8 data memory. It shares the single memory port between the CPU load/store path and a DMA/debug requester. It drives the memory's address, write-enable, read-enable and write-data lines with the memory's posedge-write / negedge-read timing, and returns read data with a one-cycle acknowledge. It also flags accesses outside the populated address range.

## Interface
- ADDR_W, 8, address width of both requesters and the memory port
- DATA_W, 8, data width
- MEM_DEPTH, 128, populated words; addresses >= MEM_DEPTH are out of range
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  reset, synchronous, active-low
- cpu_req  in  1  CPU request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid when cpu_ack=1 and access was a read
- cpu_err  out  1  out-of-range flag, valid with cpu_ack
- dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata, dma_err: same directions, widths and meaning for the DMA port
- mem_addr  out  ADDR_W  to memory address
- mem_we  out  1  to memory write enable
- mem_re  out  1  to memory read enable
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory read data, updated on negedge
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: the arbiter samples cpu_req and dma_req.
  - If either is high, it picks a winner, latches we, addr and wdata, and goes to ACCESS.
  - With no request it stays in IDLE.
- ACCESS: lasts exactly one cycle.
  - mem_addr = latched address.
  - For an in-range write: mem_we=1, mem_wdata=latched data.
  - For an in-range read: mem_re=1.
  - For an out-of-range address (addr >= MEM_DEPTH): mem_we and mem_re both stay 0 and the error is latched.
  - Next state is DONE.
- DONE: the winner's ack pulses for one cycle.
  - For a read, rdata = mem_rdata captured on the posedge that enters DONE.
  - err = latched range error. rdata = 0 on error.
  - The loser's ack stays 0.
  - Next state is IDLE unconditionally. Requests are ignored in DONE.
- Handshake:
  - A requester must hold req, we, addr and wdata stable until its ack.
  - If req is still high in IDLE after the ack, it is a new request.
- Arbitration: see Configuration. A losing request stays pending, with no starvation under round-robin.
- mem_we, mem_re and mem_addr return to 0 outside ACCESS.

## Timing
- Request sampled at posedge N, memory signals valid in cycle N+1, ack in cycle N+2.
  - Write: the memory commits at posedge N+2.
  - Read: the memory drives mem_rdata at the negedge inside cycle N+1, and the arbiter captures it at posedge N+2.
- Throughput: one access per 3 cycles. Back-to-back requests from both ports alternate or serialize per the arbitration policy.
- Reset values: state IDLE, and every output 0 (acks, errs, rdata, mem_*, busy).
- Reset sampled low in ACCESS: the state returns to IDLE and no ack is issued.
  - The memory itself has no reset, so a write already presented at that posedge is committed.
  - The requester must re-issue.
- The round-robin pointer resets to favour the CPU.

## Configuration
- DMA_ROUND_ROBIN_EN defined: round-robin arbitration.
  - On simultaneous requests the port that did not win last goes first.
  - The pointer updates on entry to ACCESS.
- Not defined: fixed priority, CPU always wins ties. DMA is served only when cpu_req=0 in IDLE.

## Structure
- Shared package data_mem_pkg holds:
  - the state enum (IDLE/ACCESS/DONE);
  - the port-select encoding (PORT_CPU=0, PORT_DMA=1);
  - the ADDR_W, DATA_W and MEM_DEPTH defaults.
- One sub-module: mem_rr_picker, a 2-input grant picker holding the last-winner pointer. It degenerates to fixed priority when DMA_ROUND_ROBIN_EN is undefined.

## Test plan
- CPU write 0x2A to addr 3, then CPU read addr 3:
  - mem_we=1 for exactly one cycle;
  - cpu_ack in cycle N+2 each time;
  - cpu_rdata=0x2A.
- DMA read of addr 8 with memory preloaded to 20: dma_ack at N+2, dma_rdata=0x14, dma_err=0, cpu_ack stays 0.
- Out-of-range CPU write to addr 200: mem_we never asserts, cpu_ack=1 with cpu_err=1, memory contents unchanged.
- Both ports request continuously:
  - with DMA_ROUND_ROBIN_EN, grants alternate CPU, DMA, CPU;
  - without it, CPU wins every slot and DMA is served only after cpu_req drops.
- reset_n driven low in the ACCESS cycle of a read: no ack issued, busy=0 and all outputs 0 the next cycle, and a following request completes normally.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the data memory arbiter.
// State encoding, port select encoding and bus width defaults.
package data_mem_pkg;

   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 8;
   localparam int MEM_DEPTH = 128;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_e;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DMA = 1'b1
   } port_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester-side bus of the data memory arbiter.
// master = requester (CPU or DMA), slave = arbiter.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = data_mem_pkg::ADDR_W,
   parameter int DATA_W = data_mem_pkg::DATA_W
);

   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;
   logic              err;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, err
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, err
   );

endinterface

// File: rtl/mem_rr_picker.sv
// Two-input grant picker with last-winner pointer.
// DMA_ROUND_ROBIN_EN selects round-robin, else CPU-first priority.
module mem_rr_picker
   import data_mem_pkg::*;
(
   input  logic  clk,
   input  logic  reset_n,
   input  logic  req_cpu_i,
   input  logic  req_dma_i,
   input  logic  update_i,
   output port_e grant_o
);

`ifdef DMA_ROUND_ROBIN_EN

   port_e last_q;

   // On a tie the port that did not win last time goes first
   always_comb begin
      grant_o = PORT_CPU;
      if (req_cpu_i && req_dma_i) begin
         grant_o = (last_q == PORT_CPU) ? PORT_DMA : PORT_CPU;
      end else if (req_dma_i) begin
         grant_o = PORT_DMA;
      end
   end

   // Pointer starts as if DMA won last, so the CPU is favoured first
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_q <= PORT_DMA;
      end else if (update_i) begin
         last_q <= grant_o;
      end
   end

`else

   logic unused_inputs;

   assign unused_inputs = ^{clk, reset_n, update_i};

   // CPU always wins; DMA only when the CPU is not asking
   always_comb begin
      grant_o = PORT_CPU;
      if (!req_cpu_i && req_dma_i) begin
         grant_o = PORT_DMA;
      end
   end

`endif

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one 128x8 data memory port between CPU and DMA requesters.
// Optional macro DMA_ROUND_ROBIN_EN: round-robin instead of CPU priority.
module data_mem_arbiter #(
   parameter int ADDR_W    = data_mem_pkg::ADDR_W,
   parameter int DATA_W    = data_mem_pkg::DATA_W,
   parameter int MEM_DEPTH = data_mem_pkg::MEM_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   data_mem_arbiter_if.slave cpu,
   data_mem_arbiter_if.slave dma,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   import data_mem_pkg::*;

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

   state_e            state_q, state_d;
   port_e             port_q, port_d;
   port_e             grant;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic              pick_upd;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_in;
   logic [DATA_W-1:0] rd_val;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_re_q, mem_re_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dma_ack_q, dma_ack_d;
   logic              cpu_err_q, cpu_err_d;
   logic              dma_err_q, dma_err_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
   logic              busy_q, busy_d;

   mem_rr_picker u_picker (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_cpu_i (cpu.req),
      .req_dma_i (dma.req),
      .update_i  (pick_upd),
      .grant_o   (grant)
   );

   // Mux the granted requester's command and range-check its address
   always_comb begin
      sel_we    = cpu.we;
      sel_addr  = cpu.addr;
      sel_wdata = cpu.wdata;
      if (grant == PORT_DMA) begin
         sel_we    = dma.we;
         sel_addr  = dma.addr;
         sel_wdata = dma.wdata;
      end
      sel_in = ({1'b0, sel_addr} < DEPTH_L);
   end

   // Next state and next registered outputs
   always_comb begin
      state_d     = state_q;
      port_d      = port_q;
      we_d        = we_q;
      err_d       = err_q;
      pick_upd    = 1'b0;
      rd_val      = '0;
      mem_addr_d  = '0;
      mem_we_d    = 1'b0;
      mem_re_d    = 1'b0;
      mem_wdata_d = '0;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_err_d   = 1'b0;
      dma_err_d   = 1'b0;
      cpu_rdata_d = '0;
      dma_rdata_d = '0;
      unique case (state_q)
         IDLE: begin
            if (cpu.req || dma.req) begin
               state_d    = ACCESS;
               pick_upd   = 1'b1;
               port_d     = grant;
               we_d       = sel_we;
               err_d      = !sel_in;
               mem_addr_d = sel_addr;
               if (sel_in) begin
                  mem_we_d = sel_we;
                  mem_re_d = !sel_we;
                  if (sel_we) begin
                     mem_wdata_d = sel_wdata;
                  end
               end
            end
         end
         ACCESS: begin
            state_d = DONE;
            if (!we_q && !err_q) begin
               rd_val = mem_rdata;
            end
            if (port_q == PORT_CPU) begin
               cpu_ack_d   = 1'b1;
               cpu_err_d   = err_q;
               cpu_rdata_d = rd_val;
            end else begin
               dma_ack_d   = 1'b1;
               dma_err_d   = err_q;
               dma_rdata_d = rd_val;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, latched command and output registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         port_q      <= PORT_CPU;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_wdata_q <= '0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         dma_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         port_q      <= port_d;
         we_q        <= we_d;
         err_q       <= err_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_re_q    <= mem_re_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_err_q   <= cpu_err_d;
         dma_err_q   <= dma_err_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         busy_q      <= busy_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign cpu.ack   = cpu_ack_q;
   assign cpu.err   = cpu_err_q;
   assign cpu.rdata = cpu_rdata_q;
   assign dma.ack   = dma_ack_q;
   assign dma.err   = dma_err_q;
   assign dma.rdata = dma_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a 128x8 memory model.
// Define DMA_ROUND_ROBIN_EN for both RTL and bench to test round-robin.
module tb_data_mem_arbiter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] mem_addr;
   logic       mem_we;
   logic       mem_re;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       busy;

   logic [7:0] mem [0:127];
   logic [7:0] snap [0:127];
   logic       init_en = 1'b1;
   logic       pre_en = 1'b0;
   logic [6:0] pre_addr = '0;
   logic [7:0] pre_data = '0;

   int checks = 0;
   int failures = 0;

   data_mem_arbiter_if cpu_if ();
   data_mem_arbiter_if dma_if ();

   data_mem_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu       (cpu_if),
      .dma       (dma_if),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_re    (mem_re),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Memory model: posedge write, negedge read
   always @(posedge clk) begin
      if (init_en) begin
         for (int i = 0; i < 128; i++) begin
            mem[i] <= 8'(i * 3 + 1);
         end
      end else if (mem_we) begin
         mem[mem_addr[6:0]] <= mem_wdata;
      end else if (pre_en) begin
         mem[pre_addr] <= pre_data;
      end
   end

   always @(negedge clk) begin
      if (mem_re) begin
         mem_rdata <= mem[mem_addr[6:0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cpu(input logic r, input logic w,
                            input logic [7:0] a,
                            input logic [7:0] d);
      cpu_if.req   = r;
      cpu_if.we    = w;
      cpu_if.addr  = a;
      cpu_if.wdata = d;
   endtask

   task automatic drive_dma(input logic r, input logic w,
                            input logic [7:0] a,
                            input logic [7:0] d);
      dma_if.req   = r;
      dma_if.we    = w;
      dma_if.addr  = a;
      dma_if.wdata = d;
   endtask

   task automatic test_reset();
      logic [7:0] ctl;
      logic [39:0] dat;
      reset_n = 1'b0;
      repeat (3) tick();
      ctl = {busy, mem_we, mem_re, cpu_if.ack, cpu_if.err,
             dma_if.ack, dma_if.err, 1'b0};
      dat = {mem_addr, mem_wdata, cpu_if.rdata, dma_if.rdata, 8'h00};
      checks++;
      if (ctl !== 8'h00) begin
         failures++;
         $display("FAIL reset_ctl got=%0h exp=0", ctl);
      end
      checks++;
      if (dat !== 40'h0) begin
         failures++;
         $display("FAIL reset_data got=%0h exp=0", dat);
      end
      @(negedge clk);
      reset_n = 1'b1;
      init_en = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_busy got=%0b exp=0", busy);
      end
   endtask

   task automatic test_cpu_write();
      int wes;
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 8'd3, 8'h2A);
      wes = 0;
      tick();
      wes += int'(mem_we);
      checks++;
      if ({busy, mem_we, mem_addr, mem_wdata, cpu_if.ack}
          !== {1'b1, 1'b1, 8'd3, 8'h2A, 1'b0}) begin
         failures++;
         $display("FAIL wr_access got=%0h exp=%0h",
                  {busy, mem_we, mem_addr, mem_wdata, cpu_if.ack},
                  {1'b1, 1'b1, 8'd3, 8'h2A, 1'b0});
      end
      tick();
      wes += int'(mem_we);
      checks++;
      if ({cpu_if.ack, cpu_if.err, dma_if.ack} !== 3'b100) begin
         failures++;
         $display("FAIL wr_ack got=%0b exp=100",
                  {cpu_if.ack, cpu_if.err, dma_if.ack});
      end
      checks++;
      if (mem[3] !== 8'h2A) begin
         failures++;
         $display("FAIL wr_commit got=%0h exp=2a", mem[3]);
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      wes += int'(mem_we);
      checks++;
      if (wes !== 1) begin
         failures++;
         $display("FAIL wr_we_cycles got=%0d exp=1", wes);
      end
      checks++;
      if ({busy, cpu_if.ack} !== 2'b00) begin
         failures++;
         $display("FAIL wr_back_idle got=%0b exp=00",
                  {busy, cpu_if.ack});
      end
   endtask

   task automatic test_cpu_read();
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 8'd3, 8'h00);
      tick();
      checks++;
      if ({mem_re, mem_we, mem_addr} !== {1'b1, 1'b0, 8'd3}) begin
         failures++;
         $display("FAIL rd_access got=%0h exp=%0h",
                  {mem_re, mem_we, mem_addr}, {1'b1, 1'b0, 8'd3});
      end
      tick();
      checks++;
      if ({cpu_if.ack, cpu_if.err, cpu_if.rdata}
          !== {1'b1, 1'b0, 8'h2A}) begin
         failures++;
         $display("FAIL rd_ack_data got=%0h exp=%0h",
                  {cpu_if.ack, cpu_if.err, cpu_if.rdata},
                  {1'b1, 1'b0, 8'h2A});
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
   endtask

   task automatic test_dma_read();
      @(negedge clk);
      pre_en   = 1'b1;
      pre_addr = 7'd8;
      pre_data = 8'd20;
      tick();
      pre_en = 1'b0;
      @(negedge clk);
      drive_dma(1'b1, 1'b0, 8'd8, 8'h00);
      tick();
      checks++;
      if ({mem_re, mem_addr, cpu_if.ack, dma_if.ack}
          !== {1'b1, 8'd8, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL dma_access got=%0h exp=%0h",
                  {mem_re, mem_addr, cpu_if.ack, dma_if.ack},
                  {1'b1, 8'd8, 1'b0, 1'b0});
      end
      tick();
      checks++;
      if ({dma_if.ack, dma_if.err, dma_if.rdata, cpu_if.ack}
          !== {1'b1, 1'b0, 8'h14, 1'b0}) begin
         failures++;
         $display("FAIL dma_ack_data got=%0h exp=%0h",
                  {dma_if.ack, dma_if.err, dma_if.rdata, cpu_if.ack},
                  {1'b1, 1'b0, 8'h14, 1'b0});
      end
      drive_dma(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
   endtask

   task automatic test_out_of_range();
      int wes;
      int diffs;
      for (int i = 0; i < 128; i++) snap[i] = mem[i];
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 8'd200, 8'h55);
      wes = 0;
      tick();
      wes += int'(mem_we) + int'(mem_re);
      checks++;
      if ({busy, mem_addr} !== {1'b1, 8'd200}) begin
         failures++;
         $display("FAIL oor_access got=%0h exp=%0h",
                  {busy, mem_addr}, {1'b1, 8'd200});
      end
      tick();
      wes += int'(mem_we) + int'(mem_re);
      checks++;
      if ({cpu_if.ack, cpu_if.err, cpu_if.rdata}
          !== {1'b1, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL oor_ack_err got=%0h exp=%0h",
                  {cpu_if.ack, cpu_if.err, cpu_if.rdata},
                  {1'b1, 1'b1, 8'h00});
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      checks++;
      if (wes !== 0) begin
         failures++;
         $display("FAIL oor_mem_strobes got=%0d exp=0", wes);
      end
      diffs = 0;
      for (int i = 0; i < 128; i++) begin
         if (mem[i] !== snap[i]) diffs++;
      end
      checks++;
      if (diffs !== 0) begin
         failures++;
         $display("FAIL oor_mem_changed got=%0d exp=0", diffs);
      end
      // Boundary: 127 is the last valid word, 128 the first invalid
      @(negedge clk);
      drive_cpu(1'b1, 1'b1, 8'd127, 8'h7E);
      tick();
      tick();
      checks++;
      if ({cpu_if.ack, cpu_if.err, mem[127]}
          !== {1'b1, 1'b0, 8'h7E}) begin
         failures++;
         $display("FAIL edge127 got=%0h exp=%0h",
                  {cpu_if.ack, cpu_if.err, mem[127]},
                  {1'b1, 1'b0, 8'h7E});
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 8'd128, 8'h00);
      tick();
      checks++;
      if ({mem_re, mem_we} !== 2'b00) begin
         failures++;
         $display("FAIL edge128_strobe got=%0b exp=00",
                  {mem_re, mem_we});
      end
      tick();
      checks++;
      if ({cpu_if.ack, cpu_if.err, cpu_if.rdata}
          !== {1'b1, 1'b1, 8'h00}) begin
         failures++;
         $display("FAIL edge128_ack got=%0h exp=%0h",
                  {cpu_if.ack, cpu_if.err, cpu_if.rdata},
                  {1'b1, 1'b1, 8'h00});
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq;
      logic [3:0] exp_seq;
      int         t [0:3];
      int         n;
      int         both;
      int         bad_data;
      int         bad_gap;
`ifdef DMA_ROUND_ROBIN_EN
      exp_seq = 4'b1010;
`else
      exp_seq = 4'b1000;
`endif
      // Fresh reset so the pointer favours the CPU
      @(negedge clk);
      reset_n = 1'b0;
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      drive_cpu(1'b1, 1'b0, 8'd3, 8'h00);
      drive_dma(1'b1, 1'b0, 8'd8, 8'h00);
      seq = '0;
      n = 0;
      both = 0;
      bad_data = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         tick();
         if (cpu_if.ack && dma_if.ack) both++;
         if (cpu_if.ack || dma_if.ack) begin
            seq[n] = dma_if.ack;
            t[n] = c;
            if (cpu_if.ack && cpu_if.rdata !== 8'h2A) bad_data++;
            if (dma_if.ack && dma_if.rdata !== 8'h14) bad_data++;
            n++;
            if (n == 3) cpu_if.req = 1'b0;
         end
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      drive_dma(1'b0, 1'b0, 8'd0, 8'd0);
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL arb_timeout got=%0d acks exp=4", n);
      end else begin
         bad_gap = 0;
         for (int i = 1; i < 4; i++) begin
            if (t[i] - t[i-1] != 3) bad_gap++;
         end
         checks++;
         if (bad_gap !== 0) begin
            failures++;
            $display("FAIL arb_spacing got=%0d bad gaps exp=0",
                     bad_gap);
         end
      end
      checks++;
      if (seq !== exp_seq) begin
         failures++;
         $display("FAIL arb_order got=%b exp=%b", seq, exp_seq);
      end
      checks++;
      if (both !== 0 || bad_data !== 0) begin
         failures++;
         $display("FAIL arb_acks got=%0d/%0d exp=0/0",
                  both, bad_data);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_in_access();
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 8'd3, 8'h00);
      tick();
      checks++;
      if (mem_re !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_access got=%0b exp=1", mem_re);
      end
      reset_n = 1'b0;
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
      checks++;
      if ({busy, mem_we, mem_re, mem_addr, cpu_if.ack,
           cpu_if.rdata, dma_if.ack} !== 20'h0) begin
         failures++;
         $display("FAIL rst_in_access got=%0h exp=0",
                  {busy, mem_we, mem_re, mem_addr, cpu_if.ack,
                   cpu_if.rdata, dma_if.ack});
      end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      checks++;
      if ({cpu_if.ack, busy} !== 2'b00) begin
         failures++;
         $display("FAIL rst_no_ack got=%0b exp=00",
                  {cpu_if.ack, busy});
      end
      @(negedge clk);
      drive_cpu(1'b1, 1'b0, 8'd3, 8'h00);
      tick();
      tick();
      checks++;
      if ({cpu_if.ack, cpu_if.err, cpu_if.rdata}
          !== {1'b1, 1'b0, 8'h2A}) begin
         failures++;
         $display("FAIL rst_reissue got=%0h exp=%0h",
                  {cpu_if.ack, cpu_if.err, cpu_if.rdata},
                  {1'b1, 1'b0, 8'h2A});
      end
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      tick();
   endtask

   initial begin
      drive_cpu(1'b0, 1'b0, 8'd0, 8'd0);
      drive_dma(1'b0, 1'b0, 8'd0, 8'd0);
      test_reset();
      test_cpu_write();
      test_cpu_read();
      test_dma_read();
      test_out_of_range();
      test_back_to_back();
      test_reset_in_access();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
